// File: rtl/pio_loader.sv
// rtl/pio_loader.sv - boot-time ROM loader and run-time push forwarder for one pio
module pio_loader #(
  parameter int         PROG_LEN = 32,
  parameter logic [3:0] ACT_LOAD = 4'd1,
  parameter logic [3:0] ACT_PUSH = 4'd4
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [4:0]  conf_addr,
  input  logic [35:0] conf_data,
  input  logic [5:0]  conf_len,
  input  logic        reload,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_data,
  input  logic [1:0]  push_mindex,
  input  logic [3:0]  pio_full,
  output logic [31:0] pio_din,
  output logic [4:0]  pio_index,
  output logic [3:0]  pio_action,
  output logic [1:0]  pio_mindex,
  output logic        loaded
);

  typedef enum logic [1:0] {LOAD_PROG, LOAD_CONF, DRAIN, RUN} state_t;

  state_t     state, state_nxt;
  logic [5:0] conf_len_q;
  logic [5:0] conf_len_clamped;
  logic       s1_valid, s1_conf, s1_last, out_last;
  logic [4:0] s1_index;
  logic       issue, issue_conf, issue_last;
  logic       accept, restart;

  assign conf_len_clamped = (conf_len > 6'd32) ? 6'd32 : conf_len;
  assign loaded           = (state == RUN);
  assign push_ready       = loaded & ~reload & ~reset & ~pio_full[push_mindex];
  assign accept           = push_valid & push_ready;
  assign restart          = loaded & reload;

  // Addresses are issued back to back across the prog/conf boundary; the
  // s1_* stage tracks each address through the ROM's read latency.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_conf = 1'b0;
    issue_last = 1'b0;
    case (state)
      LOAD_PROG: begin
        issue = 1'b1;
        if (prog_addr == 5'(PROG_LEN - 1)) begin
          if (conf_len_q == 6'd0) begin
            issue_last = 1'b1;
            state_nxt  = DRAIN;
          end else begin
            state_nxt = LOAD_CONF;
          end
        end
      end
      LOAD_CONF: begin
        issue      = 1'b1;
        issue_conf = 1'b1;
        if ({1'b0, conf_addr} == conf_len_q - 6'd1) begin
          issue_last = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (out_last) state_nxt = RUN;
      end
      RUN: begin
        if (reload) state_nxt = LOAD_PROG;
      end
      default: state_nxt = LOAD_PROG;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state      <= LOAD_PROG;
      prog_addr  <= 5'd0;
      conf_addr  <= 5'd0;
      conf_len_q <= conf_len_clamped;
      s1_valid   <= 1'b0;
      s1_conf    <= 1'b0;
      s1_last    <= 1'b0;
      s1_index   <= 5'd0;
      out_last   <= 1'b0;
      pio_din    <= 32'd0;
      pio_index  <= 5'd0;
      pio_action <= 4'd0;
      pio_mindex <= 2'd0;
    end else begin
      state <= state_nxt;
      if (restart) conf_len_q <= conf_len_clamped;
      if (issue && !issue_conf)
        prog_addr <= (prog_addr == 5'(PROG_LEN - 1)) ? 5'd0 : prog_addr + 5'd1;
      if (issue_conf)
        conf_addr <= issue_last ? 5'd0 : conf_addr + 5'd1;
      s1_valid <= issue;
      s1_conf  <= issue_conf;
      s1_last  <= issue_last;
      s1_index <= prog_addr;
      out_last <= s1_valid & s1_last;
      if (s1_valid) begin
        pio_action <= s1_conf ? conf_data[35:32] : ACT_LOAD;
        pio_din    <= s1_conf ? conf_data[31:0] : {16'h0, prog_data};
        pio_index  <= s1_conf ? 5'd0 : s1_index;
        pio_mindex <= 2'd0;
      end else if (accept) begin
        pio_action <= ACT_PUSH;
        pio_din    <= push_data;
        pio_index  <= 5'd0;
        pio_mindex <= push_mindex;
      end else begin
        pio_action <= 4'd0;
      end
    end
  end

endmodule
